// File: rtl/i2c_pkg.sv
// Shared types for the sensor poll sequencer and the byte-level I2C master.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_INIT_ISSUE = 3'd0,
        ST_INIT_WAIT  = 3'd1,
        ST_IDLE       = 3'd2,
        ST_RD_ISSUE   = 3'd3,
        ST_RD_WAIT    = 3'd4,
        ST_FAULT      = 3'd5
    } poll_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       rw;
        logic [6:0] slave_addr;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } i2c_rsp_t;

    // Register address inside a frame; wraps modulo 256 by construction.
    function automatic logic [7:0] reg_at(input logic [7:0] base, input logic [7:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// Free-running poll period counter with a single pending-poll flag and overrun pulse.
module i2c_poll_timer #(
    parameter int unsigned PERIOD_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic busy_rd,
    input  logic consume,
    output logic poll_due,
    output logic overrun
);

    localparam int unsigned CW = (PERIOD_CYC > 2) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

    logic [CW-1:0] count_reg, count_next;
    logic          due_reg, due_next;
    logic          overrun_reg, overrun_next;
    logic          tick;

    always_comb begin
        tick         = run && (count_reg == LAST);
        count_next   = count_reg;
        due_next     = due_reg;
        overrun_next = 1'b0;
        if (clr) begin
            count_next = '0;
            due_next   = 1'b0;
        end else begin
            if (run) begin
                count_next = tick ? '0 : count_reg + CW'(1);
            end
            // A fresh tick wins over a same-cycle consume; only one poll is ever pending.
            if (tick) begin
                due_next     = 1'b1;
                overrun_next = busy_rd;
            end else if (consume) begin
                due_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            due_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            due_reg     <= due_next;
            overrun_reg <= overrun_next;
        end
    end

    assign poll_due = due_reg;
    assign overrun  = overrun_reg;

endmodule

// File: rtl/i2c_poll_sched.sv
// Sensor poll sequencer: one init write, then periodic burst reads streamed out byte by byte,
// with per-transaction retry and a sticky fault on persistent bus errors.
module i2c_poll_sched
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h68,
    parameter logic [7:0]  INIT_REG   = 8'h6B,
    parameter logic [7:0]  INIT_DATA  = 8'h00,
    parameter logic [7:0]  BASE_REG   = 8'h3B,
    parameter int unsigned NUM_REGS   = 14,
    parameter int unsigned PERIOD_CYC = 100000,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fault_clr,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_rw,
    output logic [6:0] cmd_slave_addr,
    output logic [7:0] cmd_reg_addr,
    output logic [7:0] cmd_wdata,
    input  logic       rsp_valid,
    input  logic       rsp_err,
    input  logic [7:0] rsp_rdata,
    output logic       sample_valid,
    output logic [7:0] sample_index,
    output logic [7:0] sample_data,
    output logic       frame_done,
    output logic       overrun,
    output logic       fault,
    output logic       busy
);

    localparam logic [7:0] LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [7:0] RETRY_LIM = 8'(MAX_RETRY);

    poll_state_t state_reg, state_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  retry_reg, retry_next;
    logic        sample_valid_reg, sample_valid_next;
    logic [7:0]  sample_index_reg, sample_index_next;
    logic [7:0]  sample_data_reg, sample_data_next;
    logic        frame_done_reg, frame_done_next;
    logic        fault_reg, fault_next;

    logic        poll_due, consume, timer_clr, timer_run, busy_rd;
    i2c_cmd_t    cmd;
    i2c_rsp_t    rsp;

    assign rsp.err   = rsp_err;
    assign rsp.rdata = rsp_rdata;

    assign timer_run = (state_reg != ST_FAULT);
    assign busy_rd   = (state_reg == ST_RD_ISSUE) || (state_reg == ST_RD_WAIT);

    i2c_poll_timer #(
        .PERIOD_CYC (PERIOD_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .run      (timer_run),
        .busy_rd  (busy_rd),
        .consume  (consume),
        .poll_due (poll_due),
        .overrun  (overrun)
    );

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        retry_next        = retry_reg;
        sample_valid_next = 1'b0;
        sample_index_next = sample_index_reg;
        sample_data_next  = sample_data_reg;
        frame_done_next   = 1'b0;
        fault_next        = fault_reg;
        consume           = 1'b0;
        timer_clr         = 1'b0;

        case (state_reg)
            ST_INIT_ISSUE, ST_RD_ISSUE: begin
                if (cmd_ready) begin
                    state_next = (state_reg == ST_INIT_ISSUE) ? ST_INIT_WAIT : ST_RD_WAIT;
                end
            end
            ST_INIT_WAIT, ST_RD_WAIT: begin
                if (rsp_valid) begin
                    if (rsp.err) begin
                        if (retry_reg < RETRY_LIM) begin
                            retry_next = retry_reg + 8'd1;
                            state_next = (state_reg == ST_INIT_WAIT) ? ST_INIT_ISSUE : ST_RD_ISSUE;
                        end else begin
                            retry_next = '0;
                            idx_next   = '0;
                            fault_next = 1'b1;
                            state_next = ST_FAULT;
                        end
                    end else begin
                        retry_next = '0;
                        if (state_reg == ST_INIT_WAIT) begin
                            consume    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            sample_valid_next = 1'b1;
                            sample_index_next = idx_reg;
                            sample_data_next  = rsp.rdata;
                            if (idx_reg == LAST_IDX) begin
                                frame_done_next = 1'b1;
                                idx_next        = '0;
                                state_next      = ST_IDLE;
                            end else if (enable) begin
                                idx_next   = idx_reg + 8'd1;
                                state_next = ST_RD_ISSUE;
                            end else begin
                                // Disabled mid-frame: stop at the transaction boundary.
                                idx_next   = '0;
                                state_next = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (poll_due && enable) begin
                    consume    = 1'b1;
                    idx_next   = '0;
                    state_next = ST_RD_ISSUE;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    fault_next = 1'b0;
                    retry_next = '0;
                    idx_next   = '0;
                    timer_clr  = 1'b1;
                    state_next = ST_INIT_ISSUE;
                end
            end
            default: state_next = ST_INIT_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_INIT_ISSUE;
            idx_reg          <= '0;
            retry_reg        <= '0;
            sample_valid_reg <= 1'b0;
            sample_index_reg <= '0;
            sample_data_reg  <= '0;
            frame_done_reg   <= 1'b0;
            fault_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            retry_reg        <= retry_next;
            sample_valid_reg <= sample_valid_next;
            sample_index_reg <= sample_index_next;
            sample_data_reg  <= sample_data_next;
            frame_done_reg   <= frame_done_next;
            fault_reg        <= fault_next;
        end
    end

    // Command fields depend only on state and index, so they hold steady while waiting for ready.
    always_comb begin
        cmd.rw         = RW_READ;
        cmd.slave_addr = SLAVE_ADDR;
        cmd.reg_addr   = reg_at(BASE_REG, idx_reg);
        cmd.wdata      = 8'h00;
        if ((state_reg == ST_INIT_ISSUE) || (state_reg == ST_INIT_WAIT)) begin
            cmd.rw       = RW_WRITE;
            cmd.reg_addr = INIT_REG;
            cmd.wdata    = INIT_DATA;
        end
    end

    assign cmd_valid      = !rst && ((state_reg == ST_INIT_ISSUE) || (state_reg == ST_RD_ISSUE));
    assign busy           = !rst && (state_reg != ST_IDLE) && (state_reg != ST_FAULT);
    assign cmd_rw         = cmd.rw;
    assign cmd_slave_addr = cmd.slave_addr;
    assign cmd_reg_addr   = cmd.reg_addr;
    assign cmd_wdata      = cmd.wdata;
    assign sample_valid   = sample_valid_reg;
    assign sample_index   = sample_index_reg;
    assign sample_data    = sample_data_reg;
    assign frame_done     = frame_done_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_i2c_poll_sched.sv
// Directed bench: two schedulers (default register window and a wrapping one) against simple slave models.
module tb_i2c_poll_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic enable = 1'b1;
    logic fault_clr = 1'b0;
    logic fault_clr_b = 1'b0;

    logic       cmd_valid, cmd_rw, cmd_ready = 1'b0;
    logic [6:0] cmd_slave_addr;
    logic [7:0] cmd_reg_addr, cmd_wdata;
    logic       rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [7:0] rsp_rdata = 8'h00;
    logic       sample_valid, frame_done, overrun, fault, busy;
    logic [7:0] sample_index, sample_data;

    logic       cmd_valid_b, cmd_rw_b, cmd_ready_b = 1'b0;
    logic [6:0] cmd_slave_addr_b;
    logic [7:0] cmd_reg_addr_b, cmd_wdata_b;
    logic       rsp_valid_b = 1'b0, rsp_err_b = 1'b0;
    logic [7:0] rsp_rdata_b = 8'h00;
    logic       sample_valid_b, frame_done_b, overrun_b, fault_b, busy_b;
    logic [7:0] sample_index_b, sample_data_b;

    i2c_poll_sched #(.NUM_REGS(14), .PERIOD_CYC(200), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault_clr(fault_clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_slave_addr(cmd_slave_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .sample_valid(sample_valid), .sample_index(sample_index), .sample_data(sample_data),
        .frame_done(frame_done), .overrun(overrun), .fault(fault), .busy(busy)
    );

    i2c_poll_sched #(.BASE_REG(8'hFE), .NUM_REGS(4), .PERIOD_CYC(200), .MAX_RETRY(3)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fault_clr(fault_clr_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rw(cmd_rw_b),
        .cmd_slave_addr(cmd_slave_addr_b), .cmd_reg_addr(cmd_reg_addr_b), .cmd_wdata(cmd_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_err(rsp_err_b), .rsp_rdata(rsp_rdata_b),
        .sample_valid(sample_valid_b), .sample_index(sample_index_b), .sample_data(sample_data_b),
        .frame_done(frame_done_b), .overrun(overrun_b), .fault(fault_b), .busy(busy_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Slave model A: configurable latency, per-register NACK budget, read data = register address.
    int         lat_a = 0;
    int         nack_cnt [256];
    bit         sa_busy = 1'b0;
    int         sa_cnt = 0;
    logic [7:0] sa_reg = 8'h00;
    logic       sa_rw = 1'b0;
    logic [8:0] cq [$];
    int         first_rd_cyc = -1;

    always @(negedge clk) begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 8'h00;
        if (rst) begin
            sa_busy   = 1'b0;
            cmd_ready = 1'b0;
        end else if (sa_busy) begin
            cmd_ready = 1'b0;
            if (sa_cnt == 0) begin
                sa_busy   = 1'b0;
                rsp_valid = 1'b1;
                rsp_rdata = sa_reg;
                if (nack_cnt[sa_reg] > 0) begin
                    rsp_err = 1'b1;
                    nack_cnt[sa_reg]--;
                end
                $display("[%0d] A txn rw=%0d reg=%02h err=%0d", cyc, sa_rw, sa_reg, rsp_err);
            end else begin
                sa_cnt--;
            end
        end else begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
                sa_busy = 1'b1;
                sa_cnt  = lat_a;
                sa_reg  = cmd_reg_addr;
                sa_rw   = cmd_rw;
                cq.push_back({cmd_rw, cmd_reg_addr});
                if (cmd_rw && first_rd_cyc < 0) first_rd_cyc = cyc;
            end
        end
    end

    // Slave model B: zero latency, always ACK, ready can be withheld.
    bit         hold_b = 1'b0;
    bit         sb_busy = 1'b0;
    logic [7:0] sb_reg = 8'h00;
    logic       sb_rw = 1'b0;
    logic [7:0] cqb [$];

    always @(negedge clk) begin
        rsp_valid_b = 1'b0;
        rsp_err_b   = 1'b0;
        rsp_rdata_b = 8'h00;
        if (rst) begin
            sb_busy     = 1'b0;
            cmd_ready_b = 1'b0;
        end else if (sb_busy) begin
            cmd_ready_b = 1'b0;
            sb_busy     = 1'b0;
            rsp_valid_b = 1'b1;
            rsp_rdata_b = sb_reg;
            $display("[%0d] B txn rw=%0d reg=%02h err=0", cyc, sb_rw, sb_reg);
        end else begin
            cmd_ready_b = !hold_b;
            if (cmd_valid_b && !hold_b) begin
                sb_busy = 1'b1;
                sb_reg  = cmd_reg_addr_b;
                sb_rw   = cmd_rw_b;
                cqb.push_back(cmd_reg_addr_b);
            end
        end
    end

    // Output monitors.
    logic [15:0] sq [$];
    logic [15:0] sqb [$];
    int          frames_a = 0, frames_b = 0, ovr_a = 0;
    logic        fd_sv = 1'b0;
    logic [7:0]  fd_idx = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (sample_valid) sq.push_back({sample_index, sample_data});
            if (overrun) ovr_a++;
            if (frame_done) begin
                frames_a++;
                fd_sv  = sample_valid;
                fd_idx = sample_index;
            end
            if (sample_valid_b) sqb.push_back({sample_index_b, sample_data_b});
            if (frame_done_b) frames_b++;
        end
    end

    function automatic int count_reg(input logic [7:0] r);
        int c = 0;
        foreach (cq[i]) if (cq[i][7:0] == r) c++;
        return c;
    endfunction

    task automatic wait_frame_a(input int budget, input string tag);
        int start = frames_a;
        int c = 0;
        while (frames_a == start && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_vec(tag, 32'(frames_a != start), 32'd1);
    endtask

    task automatic wait_frame_b(input int budget, input string tag);
        int start = frames_b;
        int c = 0;
        while (frames_b == start && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_vec(tag, 32'(frames_b != start), 32'd1);
    endtask

    task automatic check_frame_a(input string tag, input logic [7:0] base, input int n);
        logic [7:0] exp_reg;
        check_vec({tag, "_count"}, sq.size(), n);
        for (int i = 0; i < sq.size() && i < n; i++) begin
            exp_reg = base + 8'(i);
            check_vec({tag, "_index"}, sq[i][15:8], i);
            check_vec({tag, "_data"}, sq[i][7:0], exp_reg);
        end
    endtask

    initial begin
        logic [7:0] exp_b [4];
        int         ovr_start, qn, fs, c;
        exp_b = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("rst_cmd_valid", cmd_valid, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_sample_valid", sample_valid, 0);
        check_vec("rst_frame_done", frame_done, 0);
        check_vec("rst_overrun", overrun, 0);
        check_vec("rst_fault", fault, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First command is the init write.
        @(negedge clk);
        check_vec("init_valid", cmd_valid, 1);
        check_vec("init_rw", cmd_rw, 0);
        check_vec("init_reg", cmd_reg_addr, 8'h6B);
        check_vec("init_wdata", cmd_wdata, 8'h00);
        check_vec("init_slave", cmd_slave_addr, 7'h68);
        check_vec("init_busy", busy, 1);

        // Frame 1: first read only after the first period tick.
        wait_frame_a(400, "frame1_timeout");
        check_vec("first_read_cycle", first_rd_cyc, 201);
        check_frame_a("frame1", 8'h3B, 14);
        check_vec("frame1_done_with_sample", fd_sv, 1);
        check_vec("frame1_done_index", fd_idx, 8'd13);
        check_vec("frame1_cmd_count", cq.size(), 15);
        if (cq.size() > 0) check_vec("frame1_first_cmd", cq[0], {1'b0, 8'h6B});

        // Frame 2: two NACKs on 3D and two on 40; retry count restarts per register.
        sq.delete();
        cq.delete();
        nack_cnt[8'h3D] = 2;
        nack_cnt[8'h40] = 2;
        wait_frame_a(400, "frame2_timeout");
        check_frame_a("frame2", 8'h3B, 14);
        check_vec("frame2_3d_issues", count_reg(8'h3D), 3);
        check_vec("frame2_40_issues", count_reg(8'h40), 3);
        check_vec("frame2_cmd_count", cq.size(), 18);
        check_vec("frame2_fault", fault, 0);

        // Frame 3: exactly MAX_RETRY NACKs still succeeds.
        sq.delete();
        cq.delete();
        nack_cnt[8'h3B] = 3;
        wait_frame_a(400, "frame3_timeout");
        check_frame_a("frame3", 8'h3B, 14);
        check_vec("frame3_3b_issues", count_reg(8'h3B), 4);
        check_vec("frame3_fault", fault, 0);

        // Frame 4: one NACK too many -> sticky fault.
        sq.delete();
        cq.delete();
        nack_cnt[8'h3B] = 4;
        c = 0;
        while (!fault && c < 400) begin
            @(negedge clk);
            c++;
        end
        check_vec("fault_set", fault, 1);
        check_vec("fault_cmd_valid", cmd_valid, 0);
        check_vec("fault_busy", busy, 0);
        check_vec("fault_3b_issues", count_reg(8'h3B), 4);
        check_vec("fault_no_samples", sq.size(), 0);
        repeat (250) @(negedge clk);
        check_vec("fault_hold", fault, 1);
        check_vec("fault_quiet", cq.size(), 4);

        // Clear the fault: init write is issued again.
        @(posedge clk);
        #1 fault_clr = 1'b1;
        @(posedge clk);
        #1 fault_clr = 1'b0;
        @(negedge clk);
        check_vec("clr_fault", fault, 0);
        check_vec("clr_cmd_valid", cmd_valid, 1);
        check_vec("clr_cmd_rw", cmd_rw, 0);
        check_vec("clr_cmd_reg", cmd_reg_addr, 8'h6B);
        repeat (5) @(negedge clk);
        check_vec("clr_cmd_count", cq.size(), 5);
        if (cq.size() == 5) check_vec("clr_init_logged", cq[4], {1'b0, 8'h6B});

        // Slow slave: 300-cycle latency against a 200-cycle period.
        lat_a = 300;
        ovr_start = ovr_a;
        sq.delete();
        wait_frame_a(5000, "slow_frame_timeout");
        check_vec("slow_frame_count", sq.size(), 14);
        check_vec("slow_overrun_range", 32'((ovr_a - ovr_start) >= 21 && (ovr_a - ovr_start) <= 22), 32'd1);
        lat_a = 0;
        wait_frame_a(60, "queued_frame_timeout");
        qn = cq.size();
        fs = frames_a;
        repeat (100) @(negedge clk);
        check_vec("no_second_queued_cmds", cq.size(), qn);
        check_vec("no_second_queued_frame", frames_a, fs);

        // Wrapping window with ready withheld for 10 cycles.
        wait_frame_b(400, "b_frame_timeout");
        hold_b = 1'b1;
        @(negedge clk);
        c = 0;
        while (!cmd_valid_b && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_vec("b_cmd_pending", cmd_valid_b, 1);
        sqb.delete();
        cqb.delete();
        for (int i = 0; i < 10; i++) begin
            check_vec("b_stall_valid", cmd_valid_b, 1);
            check_vec("b_stall_fields", {cmd_rw_b, cmd_slave_addr_b, cmd_reg_addr_b, cmd_wdata_b},
                      {1'b1, 7'h68, 8'hFE, 8'h00});
            @(negedge clk);
        end
        hold_b = 1'b0;
        wait_frame_b(100, "b_frame2_timeout");
        check_vec("b_sample_count", sqb.size(), 4);
        check_vec("b_cmd_count", cqb.size(), 4);
        for (int i = 0; i < 4 && i < sqb.size(); i++) begin
            check_vec("b_sample_index", sqb[i][15:8], i);
            check_vec("b_sample_data", sqb[i][7:0], exp_b[i]);
        end
        for (int i = 0; i < 4 && i < cqb.size(); i++) begin
            check_vec("b_reg_addr", cqb[i], exp_b[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
